// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and data load/store.
// Data has priority; a starvation counter forces a fetch grant after STARVE_LIMIT data wins.
`timescale 1ns/1ps
module mem_arbiter #(
   parameter int ADDR_SIZE    = 18,
   parameter int WORD_SIZE    = 18,
   parameter int STARVE_LIMIT = 3
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 code_req,
   input  logic [ADDR_SIZE-1:0] code_addr,
   output logic                 code_gnt,
   output logic                 code_rvalid,
   output logic [WORD_SIZE-1:0] code_rdata,
   input  logic                 data_req,
   input  logic                 data_we,
   input  logic [ADDR_SIZE-1:0] data_addr,
   input  logic [WORD_SIZE-1:0] data_wdata,
   output logic                 data_gnt,
   output logic                 data_rvalid,
   output logic [WORD_SIZE-1:0] data_rdata,
   output logic [ADDR_SIZE-1:0] mem_addr,
   output logic                 mem_we,
   output logic [WORD_SIZE-1:0] mem_wdata,
   input  logic [WORD_SIZE-1:0] mem_rdata
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_CODE = 2'd1, OWN_DATA = 2'd2} owner_t;

   owner_t     rd_owner;
   logic [3:0] starve_cnt;
   logic       code_wins;
   logic       data_wins;

   function automatic logic [3:0] sat_inc(input logic [3:0] cnt);
      return (cnt >= LIMIT) ? LIMIT : cnt + 4'd1;
   endfunction

   // Arbitration stage: combinational grant and RAM drive
   always_comb begin
      code_wins = code_req && (!data_req || (starve_cnt == LIMIT));
      data_wins = data_req && !code_wins;
      code_gnt  = code_wins;
      data_gnt  = data_wins;
      mem_we    = data_wins && data_we;
      mem_wdata = data_wdata;
      if (data_wins)
         mem_addr = data_addr;
      else if (code_wins)
         mem_addr = code_addr;
      else
         mem_addr = '0;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         starve_cnt <= 4'd0;
         rd_owner   <= OWN_NONE;
      end else begin
         if (code_wins || !code_req)
            starve_cnt <= 4'd0;
         else if (data_wins)
            starve_cnt <= sat_inc(starve_cnt);

         if (code_wins)
            rd_owner <= OWN_CODE;
         else if (data_wins && !data_we)
            rd_owner <= OWN_DATA;
         else
            rd_owner <= OWN_NONE;
      end
   end

   // Return stage: RAM word arrives one cycle after the grant
   always_comb begin
      code_rvalid = (rd_owner == OWN_CODE);
      data_rvalid = (rd_owner == OWN_DATA);
      code_rdata  = mem_rdata;
      data_rdata  = mem_rdata;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural synchronous RAM model.
`timescale 1ns/1ps
module tb_mem_arbiter;

   localparam int AW = 18;
   localparam int WW = 18;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          code_req = 1'b0;
   logic [AW-1:0] code_addr = '0;
   logic          code_gnt, code_rvalid;
   logic [WW-1:0] code_rdata;
   logic          data_req = 1'b0, data_we = 1'b0;
   logic [AW-1:0] data_addr = '0;
   logic [WW-1:0] data_wdata = '0;
   logic          data_gnt, data_rvalid;
   logic [WW-1:0] data_rdata;
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [WW-1:0] mem_wdata;
   logic [WW-1:0] mem_rdata = '0;

   logic [WW-1:0] ram [0:(1<<AW)-1];

   int n_checks = 0;
   int n_pass   = 0;

   mem_arbiter #(.ADDR_SIZE(AW), .WORD_SIZE(WW), .STARVE_LIMIT(3)) dut (
      .clock(clock), .reset(reset),
      .code_req(code_req), .code_addr(code_addr), .code_gnt(code_gnt),
      .code_rvalid(code_rvalid), .code_rdata(code_rdata),
      .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
      .data_wdata(data_wdata), .data_gnt(data_gnt),
      .data_rvalid(data_rvalid), .data_rdata(data_rdata),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic cr, input logic [AW-1:0] ca,
                        input logic dr, input logic we,
                        input logic [AW-1:0] da, input logic [WW-1:0] wd);
      code_req = cr; code_addr = ca;
      data_req = dr; data_we = we; data_addr = da; data_wdata = wd;
      #1;
   endtask

   initial begin
      string seq;
      string exp_seq;
      int    peak;
      for (int i = 0; i < 16; i++) ram[i] = WW'(32'h100 + i);

      // reset state
      #2;
      check("rst_code_rvalid", 32'(code_rvalid), 0);
      check("rst_data_rvalid", 32'(data_rvalid), 0);
      check("rst_starve", 32'(dut.starve_cnt), 0);
      step(); step();
      reset = 1'b1;

      // idle
      drive(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         check("idle_mem_we", 32'(mem_we), 0);
         check("idle_mem_addr", 32'(mem_addr), 0);
         check("idle_gnt", 32'({code_gnt, data_gnt}), 0);
         step();
         check("idle_rvalid", 32'({code_rvalid, data_rvalid}), 0);
      end

      // fetch only
      for (int i = 0; i < 3; i++) begin
         drive(1, AW'(i), 0, 0, 0, 0);
         check("fetch_gnt", 32'({code_gnt, data_gnt}), 32'b10);
         check("fetch_addr", 32'(mem_addr), 32'(i));
         step();
         check("fetch_rvalid", 32'({code_rvalid, data_rvalid}), 32'b10);
         check("fetch_rdata", 32'(code_rdata), 32'h100 + 32'(i));
      end
      drive(0, 0, 0, 0, 0, 0);
      step();
      check("fetch_end_rvalid", 32'({code_rvalid, data_rvalid}), 0);

      // data write then read-back
      drive(0, 0, 1, 1, 5, 18'h2AAAA);
      check("wr_gnt", 32'({code_gnt, data_gnt}), 32'b01);
      check("wr_mem_we", 32'(mem_we), 1);
      check("wr_mem_addr", 32'(mem_addr), 5);
      check("wr_mem_wdata", 32'(mem_wdata), 32'h2AAAA);
      step();
      check("wr_no_rvalid", 32'({code_rvalid, data_rvalid}), 0);
      drive(0, 0, 1, 0, 5, 0);
      check("rd_mem_we", 32'(mem_we), 0);
      check("rd_gnt", 32'(data_gnt), 1);
      step();
      check("rd_rvalid", 32'({code_rvalid, data_rvalid}), 32'b01);
      check("rd_rdata", 32'(data_rdata), 32'h2AAAA);
      drive(0, 0, 0, 0, 0, 0);
      step();

      // contention with STARVE_LIMIT = 3
      seq = ""; exp_seq = "DDDCDDDC"; peak = 0;
      drive(1, 7, 1, 0, 1, 0);
      for (int i = 0; i < 8; i++) begin
         if (int'(dut.starve_cnt) > peak) peak = int'(dut.starve_cnt);
         if (code_gnt && !data_gnt) seq = {seq, "C"};
         else if (data_gnt && !code_gnt) seq = {seq, "D"};
         else seq = {seq, "X"};
         step();
         if (i > 0 && code_rvalid) check("cont_code_rdata", 32'(code_rdata), 32'h107);
         if (data_rvalid) check("cont_data_rdata", 32'(data_rdata), 32'h101);
      end
      n_checks++;
      if (seq == exp_seq) n_pass++;
      else $display("FAIL cont_seq: got %s, want %s", seq, exp_seq);
      check("cont_peak", 32'(peak), 3);

      // code withdrawn when limit reached: data wins, counter clears
      drive(1, 7, 1, 0, 1, 0);
      step(); step(); step();
      drive(0, 0, 1, 0, 1, 0);
      check("wd_starve_at_limit", 32'(dut.starve_cnt), 3);
      check("wd_gnt", 32'({code_gnt, data_gnt}), 32'b01);
      step();
      check("wd_starve_clear", 32'(dut.starve_cnt), 0);
      drive(0, 0, 0, 0, 0, 0);
      step();

      // alternating owners
      drive(1, 2, 0, 0, 0, 0);
      check("alt_c1_gnt", 32'(code_gnt), 1);
      step();
      check("alt_c1_rvalid", 32'({code_rvalid, data_rvalid}), 32'b10);
      check("alt_c1_rdata", 32'(code_rdata), 32'h102);
      drive(0, 0, 1, 0, 5, 0);
      check("alt_d_gnt", 32'(data_gnt), 1);
      step();
      check("alt_d_rvalid", 32'({code_rvalid, data_rvalid}), 32'b01);
      check("alt_d_rdata", 32'(data_rdata), 32'h2AAAA);
      drive(1, 3, 0, 0, 0, 0);
      check("alt_c2_gnt", 32'(code_gnt), 1);
      step();
      check("alt_c2_rvalid", 32'({code_rvalid, data_rvalid}), 32'b10);
      check("alt_c2_rdata", 32'(code_rdata), 32'h103);
      drive(0, 0, 0, 0, 0, 0);
      step();

      // reset mid-read
      drive(0, 0, 1, 0, 4, 0);
      check("rmr_gnt", 32'(data_gnt), 1);
      reset = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      step();
      check("rmr_rvalid_dropped", 32'({code_rvalid, data_rvalid}), 0);
      step();
      check("rmr_rvalid_in_rst", 32'({code_rvalid, data_rvalid}), 0);
      reset = 1'b1;
      drive(0, 0, 1, 0, 5, 0);
      check("rel_starve", 32'(dut.starve_cnt), 0);
      check("rel_gnt", 32'({code_gnt, data_gnt}), 32'b01);
      step();
      check("rel_rvalid", 32'({code_rvalid, data_rvalid}), 32'b01);
      check("rel_rdata", 32'(data_rdata), 32'h2AAAA);
      drive(0, 0, 0, 0, 0, 0);
      step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares one single-port synchronous memory between the processor's instruction fetch port and its data load/store port. It sits between `processor` and the unified code/data RAM. Each cycle it grants at most one access and drives the RAM. It returns read data one cycle later to the requester that issued the read. Data accesses have priority; a starvation counter guarantees fetch progress.

## Interface
- `ADDR_SIZE`, 18, address width of both ports and the RAM.
- `WORD_SIZE`, 18, data word width.
- `STARVE_LIMIT`, 3, maximum consecutive data grants while a fetch is pending; legal range 1..15.

- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; asserting it clears all state immediately.
- `code_req`  in  1  fetch request; read only.
- `code_addr`  in  ADDR_SIZE  fetch address.
- `code_gnt`  out  1  fetch accepted this cycle (combinational).
- `code_rvalid`  out  1  `code_rdata` valid this cycle (registered).
- `code_rdata`  out  WORD_SIZE  fetched word.
- `data_req`  in  1  data access request.
- `data_we`  in  1  1 = write, 0 = read.
- `data_addr`  in  ADDR_SIZE  data address.
- `data_wdata`  in  WORD_SIZE  write data.
- `data_gnt`  out  1  data access accepted this cycle (combinational).
- `data_rvalid`  out  1  `data_rdata` valid this cycle (registered); reads only.
- `data_rdata`  out  WORD_SIZE  read word.
- `mem_addr`  out  ADDR_SIZE  RAM address.
- `mem_we`  out  1  RAM write strobe.
- `mem_wdata`  out  WORD_SIZE  RAM write data.
- `mem_rdata`  in  WORD_SIZE  RAM read data, valid one cycle after the address.

## Operation
**Winner selection** (combinational, every cycle):
- Neither request: no grant. `mem_we` = 0 and `mem_addr` = 0.
- One request: that requester wins.
- Both requests: data wins, unless `starve_cnt` == STARVE_LIMIT; then code wins.

**Winner outputs:**
- The winner's `*_gnt` = 1 and the loser's = 0.
- `mem_addr` takes the winner's address.
- `mem_we` = `data_we` only when data wins; otherwise 0.
- `mem_wdata` = `data_wdata`, always.
- A requester that loses must hold its request and address stable until granted. The arbiter does not check this.

**Starvation counter** (`starve_cnt`, 4 bits):
- Increments when data is granted while `code_req` = 1.
- Clears to 0 when code is granted or when `code_req` = 0.
- Saturates at STARVE_LIMIT.

**Read return pipeline** (`rd_owner` register, 2 bits: none/code/data):
- Loaded each edge with the owner of a granted read. A data write or no grant loads "none".
- While `rd_owner` = code: `code_rvalid` = 1 and `code_rdata` = `mem_rdata`.
- While `rd_owner` = data: `data_rvalid` = 1 and `data_rdata` = `mem_rdata`.
- `*_rdata` is don't-care when its `rvalid` = 0; drive it from `mem_rdata`.

**Other rules:**
- Back-to-back grants every cycle are allowed. The return pipeline is one deep and never stalls.
- Writes are complete at the grant edge. A read of the same address on the next cycle returns the new value; that is a RAM property, which the arbiter relies on.

## Timing
- Grant latency: 0 cycles; `gnt` is combinational on `req` and `starve_cnt`.
- Read latency: `rvalid` is asserted exactly 1 cycle after the grant.
- Throughput: 1 access per cycle total.
- Worst-case fetch wait under continuous data traffic: STARVE_LIMIT cycles; the fetch is granted on cycle STARVE_LIMIT+1.

**Reset (`reset` low):**
- `rd_owner` = none, `starve_cnt` = 0.
- `code_rvalid` = `data_rvalid` = 0, asynchronously.
- `gnt` and `mem_*` still follow the combinational rules. Requesters must not request during reset.
- A read granted in the cycle before reset is dropped; no `rvalid` follows.

**Release:** first arbitration on the first edge after `reset` goes high, with `starve_cnt` = 0.

**Simultaneous events:**
- Code request withdrawn in the same cycle the limit is reached: data wins, counter clears.
- Grant on the same edge as `rvalid`: both proceed independently.

## Test plan
- **Fetch only:** `code_req` = 1 with addresses 0,1,2; RAM preloaded with addr+0x100. Expect `code_gnt` = 1 every cycle, then `code_rvalid` one cycle later with 0x100, 0x101, 0x102. `data_rvalid` stays 0.
- **Data write then read:** write 0x2AAAA to address 5; next cycle read address 5. Expect `mem_we` = 1 only in the first cycle, no `rvalid` for the write, and `data_rvalid` = 1 with 0x2AAAA on the cycle after the read grant.
- **Contention/starvation, STARVE_LIMIT = 3:** `code_req` and `data_req` held high for 8 cycles. Grant sequence must be D,D,D,C,D,D,D,C; `starve_cnt` peaks at 3.
- **Alternating owners:** code read A, data read B, code read C on consecutive cycles. `rvalid` returns go to code, data, code in that order, each with the matching word.
- **Reset mid-read:** data read granted, then `reset` driven low before the next edge. `data_rvalid` stays 0. After release with only `data_req` high, the first grant occurs on the first edge after release and `starve_cnt` = 0.
- **Idle:** no requests for 5 cycles. Expect `mem_we` = 0, `mem_addr` = 0, and no `gnt` or `rvalid`.
